mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Parametrised memory stage for the 5-stage RV32 pipeline: performs data-memory loads/stores with byte/halfword/word sizing, sign/zero extension and optional multi-cycle memory latency, then registers results into the MEM/WB boundary. Sits between the execute-stage EX/MEM register and the writeback mux. A stall output tells the hazard unit to freeze earlier stages while a slow access is in flight.

## Interface
- DEPTH, 256: data memory words (power of two, ≥4).
- MEM_LAT, 0: extra wait cycles per load/store (0..15); 0 = single-cycle access.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  one clock; reset is asynchronous and active-high.
- RegWrite_M  in  1  writeback enable from EX/MEM.
- MemWrite_M  in  1  store request.
- MemRead_M  in  1  load request.
- ResultSrc_M  in  2  writeback select, passed through.
- Funct3_M  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010 only).
- RD_M  in  5  destination register.
- PCPlus4_M, ALU_Result_M, WriteData_M  in  32 each  PC+4, effective address, store data.
- Stall_M  out  1  combinational; high while an access is waiting.
- RegWrite_W, ResultSrc_W (2), RD_W (5), PCPlus4_W, ALU_Result_W, ReadData_W (32)  out  registered MEM/WB outputs.
- Misaligned_W  out  1  registered; access in this W slot was misaligned and suppressed.

## Operation
- Word index = ALU_Result_M[$clog2(DEPTH)+1:2]; higher address bits ignored (wrap-around modulo DEPTH words). Byte lane = ALU_Result_M[1:0].
- Stores: SB writes one lane (WriteData_M[7:0]), SH writes lanes {1,0} or {3,2} (WriteData_M[15:0]), SW all four; other lanes unchanged.
- Loads: selected byte/half shifted to bit 0; B/H sign-extend, BU/HU zero-extend, W unchanged. Non-load slots still capture the extracted read value (don't-care to writeback).
- MemRead_M and MemWrite_M both high: treated as store; ReadData_W = pre-store contents.
- Misaligned: H/HU with addr[0]=1, W with addr[1:0]≠0. No memory write, no wait states, RegWrite_W forced 0, Misaligned_W=1.
- FSM states IDLE, BUSY; 4-bit counter cnt.
  - IDLE, aligned access, MEM_LAT>0: Stall_M=1, W captures bubble, → BUSY, cnt=MEM_LAT-1.
  - BUSY, cnt≠0: Stall_M=1, bubble to W, cnt−1.
  - BUSY, cnt=0: Stall_M=0, memory write/read performed, W captures real slot, → IDLE.
  - IDLE, no access or MEM_LAT=0 or misaligned: Stall_M=0, slot completes this cycle.
- Upstream holds all _M inputs stable while Stall_M=1; stage does not re-latch them.
- Bubble = RegWrite_W=0, Misaligned_W=0, other W fields 0.
- Memory contents are not reset.

## Timing
- Reset (async assert, sync-safe release): state IDLE, cnt 0, all W outputs 0, Misaligned_W 0; Stall_M 0 while rst high. Reset mid-BUSY aborts the access with no memory write.
- Latency M→W: 1 cycle when no wait; MEM_LAT+1 cycles for aligned load/store (MEM_LAT stall cycles).
- Store becomes visible to a load presented in the following cycle.
- Throughput: one slot/cycle with MEM_LAT=0; back-to-back accesses each pay full MEM_LAT.

## Configuration
- MEMSTAGE_MISALIGN_TRAP_EN defined: misalignment detection/suppression as above.
- Undefined: no check; addr[1:0] used only for lane select, half at lane 3 takes lanes {3,2}, word ignores addr[1:0]; access performed normally with wait states; Misaligned_W tied 0.

## Test plan
- Reset: assert rst mid-BUSY (MEM_LAT=3) → all W outputs 0, Stall_M 0, target word unchanged.
- MEM_LAT=0: SW 0xDEADBEEF @0x10, then LB @0x13 → ReadData_W=0xFFFFFFDE; LBU @0x13 → 0x000000DE; LH @0x12 → 0xFFFFDEAD.
- MEM_LAT=0: SB 0x55 @0x11 over 0x11223344 at 0x10 → LW @0x10 returns 0x11225544.
- MEM_LAT=2: LW @0x20 → Stall_M high exactly 2 cycles, two bubbles in W (RegWrite_W=0), data valid on 3rd W slot.
- Trap enabled: SW 0xAAAAAAAA @0x22, RegWrite_M=1 → Misaligned_W=1, RegWrite_W=0, no stall, word @0x20 unchanged.
- DEPTH=256: SW 0x1234 @0x400 then LW @0x000 → 0x00001234 (wrap-around).

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: EX/MEM slot inputs, stall back-pressure and registered MEM/WB outputs.
// master drives the _M slot and observes the stall and _W results; slave is the stage itself.
interface mem_wb_stage_if;
  logic        RegWrite_M;
  logic        MemWrite_M;
  logic        MemRead_M;
  logic [1:0]  ResultSrc_M;
  logic [2:0]  Funct3_M;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4_M;
  logic [31:0] ALU_Result_M;
  logic [31:0] WriteData_M;
  logic        Stall_M;
  logic        RegWrite_W;
  logic [1:0]  ResultSrc_W;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4_W;
  logic [31:0] ALU_Result_W;
  logic [31:0] ReadData_W;
  logic        Misaligned_W;

  modport master (
    output RegWrite_M, MemWrite_M, MemRead_M, ResultSrc_M, Funct3_M, RD_M,
    output PCPlus4_M, ALU_Result_M, WriteData_M,
    input  Stall_M,
    input  RegWrite_W, ResultSrc_W, RD_W, PCPlus4_W, ALU_Result_W, ReadData_W, Misaligned_W
  );

  modport slave (
    input  RegWrite_M, MemWrite_M, MemRead_M, ResultSrc_M, Funct3_M, RD_M,
    input  PCPlus4_M, ALU_Result_M, WriteData_M,
    output Stall_M,
    output RegWrite_W, ResultSrc_W, RD_W, PCPlus4_W, ALU_Result_W, ReadData_W, Misaligned_W
  );
endinterface

// File: rtl/mem_wb_stage.sv
// RV32 memory stage with sized loads/stores, optional wait states and the MEM/WB register.
// Define MEMSTAGE_MISALIGN_TRAP_EN to detect and suppress misaligned half/word accesses.
module mem_wb_stage #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned MEM_LAT = 0
) (
  input logic           clk,
  input logic           rst,
  mem_wb_stage_if.slave bus
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic [3:0]  LatM1 = (MEM_LAT == 0) ? 4'd0 : 4'(MEM_LAT - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          access, misaligned, needs_wait, stall, complete, mem_we;
  logic [31:0]   rword, load_val, wdata, merged;
  logic [3:0]    be;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic          unused_addr;

  logic        regwrite_q, regwrite_d, mis_q, mis_d;
  logic [1:0]  resultsrc_q, resultsrc_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] pc_q, pc_d, alu_q, alu_d, data_q, data_d;

  // Upper address bits beyond the memory size wrap around and are deliberately ignored.
  assign idx         = bus.ALU_Result_M[AW+1:2];
  assign lane        = bus.ALU_Result_M[1:0];
  assign unused_addr = ^bus.ALU_Result_M[31:AW+2];
  assign access      = bus.MemRead_M | bus.MemWrite_M;

`ifdef MEMSTAGE_MISALIGN_TRAP_EN
  assign misaligned = access && ((bus.Funct3_M[1:0] == 2'b01 && lane[0]) ||
                                 (bus.Funct3_M[1:0] == 2'b10 && lane != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign needs_wait = access && !misaligned && (MEM_LAT != 0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: if (needs_wait) begin
        state_d = StBusy;
        cnt_d   = LatM1;
      end
      StBusy: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    unique case (state_q)
      StIdle:  stall = needs_wait;
      StBusy:  stall = (cnt_q != 4'd0);
      default: stall = 1'b0;
    endcase
    if (rst) stall = 1'b0;
  end

  assign complete    = ~stall;
  assign bus.Stall_M = stall;

  assign rword = mem[idx];
  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    case (bus.Funct3_M)
      3'b000:  load_val = {{24{rbyte[7]}}, rbyte};
      3'b001:  load_val = {{16{rhalf[15]}}, rhalf};
      3'b100:  load_val = {24'd0, rbyte};
      3'b101:  load_val = {16'd0, rhalf};
      default: load_val = rword;
    endcase
  end

  always_comb begin
    be    = 4'b1111;
    wdata = bus.WriteData_M;
    case (bus.Funct3_M[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{bus.WriteData_M[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.WriteData_M[15:0]}};
      end
      default: ;
    endcase
    for (int unsigned b = 0; b < 4; b++) begin
      merged[8*b +: 8] = be[b] ? wdata[8*b +: 8] : rword[8*b +: 8];
    end
  end

  // rst gate keeps an access aborted by reset from landing in memory.
  assign mem_we = bus.MemWrite_M && complete && !misaligned && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= merged;
  end

  always_comb begin
    regwrite_d  = 1'b0;
    resultsrc_d = '0;
    rd_d        = '0;
    pc_d        = '0;
    alu_d       = '0;
    data_d      = '0;
    mis_d       = 1'b0;
    if (complete) begin
      regwrite_d  = bus.RegWrite_M & ~misaligned;
      resultsrc_d = bus.ResultSrc_M;
      rd_d        = bus.RD_M;
      pc_d        = bus.PCPlus4_M;
      alu_d       = bus.ALU_Result_M;
      data_d      = load_val;
      mis_d       = misaligned;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_q  <= 1'b0;
      resultsrc_q <= '0;
      rd_q        <= '0;
      pc_q        <= '0;
      alu_q       <= '0;
      data_q      <= '0;
      mis_q       <= 1'b0;
    end else begin
      regwrite_q  <= regwrite_d;
      resultsrc_q <= resultsrc_d;
      rd_q        <= rd_d;
      pc_q        <= pc_d;
      alu_q       <= alu_d;
      data_q      <= data_d;
      mis_q       <= mis_d;
    end
  end

  assign bus.RegWrite_W   = regwrite_q;
  assign bus.ResultSrc_W  = resultsrc_q;
  assign bus.RD_W         = rd_q;
  assign bus.PCPlus4_W    = pc_q;
  assign bus.ALU_Result_W = alu_q;
  assign bus.ReadData_W   = data_q;
  assign bus.Misaligned_W = mis_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: a zero-latency and a two-wait-state instance share
// one stimulus set; sel routes accesses to one of them and picks which outputs are observed.
module tb_mem_wb_stage;
  localparam int unsigned Depth = 256;
  localparam int unsigned Lat   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        m_rw = 1'b0, m_mw = 1'b0, m_mr = 1'b0;
  logic [1:0]  m_rs = '0;
  logic [2:0]  m_f3 = '0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_pc = '0, m_alu = '0, m_wd = '0;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mdl [2][Depth];

  mem_wb_stage_if bus0 ();
  mem_wb_stage_if bus2 ();

  assign bus0.RegWrite_M   = m_rw;
  assign bus0.MemWrite_M   = m_mw & ~sel;
  assign bus0.MemRead_M    = m_mr & ~sel;
  assign bus0.ResultSrc_M  = m_rs;
  assign bus0.Funct3_M     = m_f3;
  assign bus0.RD_M         = m_rd;
  assign bus0.PCPlus4_M    = m_pc;
  assign bus0.ALU_Result_M = m_alu;
  assign bus0.WriteData_M  = m_wd;
  assign bus2.RegWrite_M   = m_rw;
  assign bus2.MemWrite_M   = m_mw & sel;
  assign bus2.MemRead_M    = m_mr & sel;
  assign bus2.ResultSrc_M  = m_rs;
  assign bus2.Funct3_M     = m_f3;
  assign bus2.RD_M         = m_rd;
  assign bus2.PCPlus4_M    = m_pc;
  assign bus2.ALU_Result_M = m_alu;
  assign bus2.WriteData_M  = m_wd;

  mem_wb_stage #(.DEPTH(Depth), .MEM_LAT(0))   u_fast (.clk(clk), .rst(rst), .bus(bus0));
  mem_wb_stage #(.DEPTH(Depth), .MEM_LAT(Lat)) u_slow (.clk(clk), .rst(rst), .bus(bus2));

  logic        o_stall, o_rw, o_mis;
  logic [1:0]  o_rs;
  logic [4:0]  o_rd;
  logic [31:0] o_pc, o_alu, o_data;
  assign o_stall = sel ? bus2.Stall_M      : bus0.Stall_M;
  assign o_rw    = sel ? bus2.RegWrite_W   : bus0.RegWrite_W;
  assign o_mis   = sel ? bus2.Misaligned_W : bus0.Misaligned_W;
  assign o_rs    = sel ? bus2.ResultSrc_W  : bus0.ResultSrc_W;
  assign o_rd    = sel ? bus2.RD_W         : bus0.RD_W;
  assign o_pc    = sel ? bus2.PCPlus4_W    : bus0.PCPlus4_W;
  assign o_alu   = sel ? bus2.ALU_Result_W : bus0.ALU_Result_W;
  assign o_data  = sel ? bus2.ReadData_W   : bus0.ReadData_W;

  function automatic logic mdl_mis(input logic [2:0] f3, input logic [1:0] lane);
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
    if (f3[1:0] == 2'b01) return lane[0];
    if (f3[1:0] == 2'b10) return lane != 2'b00;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] lane);
    logic [31:0] v;
    int unsigned boff, hoff;
    boff = 8 * int'(lane);
    hoff = (lane >= 2'd2) ? 16 : 0;
    case (f3)
      3'b000, 3'b100: begin
        v = (w >> boff) & 32'hFF;
        if (f3 == 3'b000 && v >= 32'd128) v = v - 32'd256;
      end
      3'b001, 3'b101: begin
        v = (w >> hoff) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] mdl_store(input logic [31:0] w, input logic [31:0] d,
                                            input logic [2:0] f3, input logic [1:0] lane);
    logic [31:0] mask;
    int unsigned sh;
    case (f3[1:0])
      2'b00:   begin sh = 8 * int'(lane); mask = 32'hFF << sh; end
      2'b01:   begin sh = (lane >= 2'd2) ? 16 : 0; mask = 32'hFFFF << sh; end
      default: begin sh = 0; mask = 32'hFFFF_FFFF; end
    endcase
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  // Called just after a rising edge; returns just after the edge that captured the slot.
  task automatic issue(input bit slow, input logic rw, input logic mw, input logic mr,
                       input logic [1:0] rs, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] wd,
                       output int stalls, output bit bubbles_ok, output bit timed_out);
    sel = slow; m_rw = rw; m_mw = mw; m_mr = mr; m_rs = rs; m_f3 = f3;
    m_rd = rd; m_pc = pc; m_alu = addr; m_wd = wd;
    stalls = 0; bubbles_ok = 1'b1; timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_stall) begin
        stalls++;
        @(posedge clk); #1;
        if ({o_rw, o_mis, o_rs, o_rd, o_pc, o_alu, o_data} !== '0) bubbles_ok = 1'b0;
      end else begin
        @(posedge clk); #1;
        timed_out = 1'b0;
        break;
      end
    end
    m_rw = 1'b0; m_mw = 1'b0; m_mr = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b1; m_rw = 1'b1; m_mr = 1'b1; m_rd = 5'd7; m_pc = 32'h44; m_alu = 32'h10;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (o_stall !== 1'b0) begin
      failures++; $display("FAIL reset_stall: got %b want 0", o_stall);
    end
    checks++;
    if ({bus0.RegWrite_W, bus0.Misaligned_W, bus0.RD_W, bus0.PCPlus4_W, bus0.ReadData_W,
         bus2.RegWrite_W, bus2.Misaligned_W, bus2.RD_W, bus2.PCPlus4_W, bus2.ReadData_W} !== '0)
    begin
      failures++; $display("FAIL reset_w: W outputs not zero (fast rd=%h slow rd=%h)",
                           bus0.RD_W, bus2.RD_W);
    end
    m_rw = 1'b0; m_mr = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fast_loads();
    int st; bit bok, to;
    issue(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'b010, 5'd0, 32'd0, 32'h10, 32'hDEADBEEF, st, bok, to);
    issue(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 3'b000, 5'd3, 32'h104, 32'h13, 32'd0, st, bok, to);
    checks++;
    if (to || st != 0 || o_data !== 32'hFFFFFFDE || o_rw !== 1'b1 || o_rd !== 5'd3) begin
      failures++; $display("FAIL lb: got data=%h stalls=%0d rw=%b want FFFFFFDE 0 1", o_data, st, o_rw);
    end
    issue(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 3'b100, 5'd3, 32'h108, 32'h13, 32'd0, st, bok, to);
    checks++;
    if (to || o_data !== 32'h000000DE) begin
      failures++; $display("FAIL lbu: got %h want 000000DE", o_data);
    end
    issue(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 3'b001, 5'd3, 32'h10C, 32'h12, 32'd0, st, bok, to);
    checks++;
    if (to || o_data !== 32'hFFFFDEAD) begin
      failures++; $display("FAIL lh: got %h want FFFFDEAD", o_data);
    end
    issue(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 3'b101, 5'd3, 32'h110, 32'h10, 32'd0, st, bok, to);
    checks++;
    if (to || o_data !== 32'h0000BEEF) begin
      failures++; $display("FAIL lhu: got %h want 0000BEEF", o_data);
    end
  endtask

  task automatic test_sb_merge();
    int st; bit bok, to;
    issue(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'b010, 5'd0, 32'd0, 32'h10, 32'h11223344, st, bok, to);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'b000, 5'd0, 32'd0, 32'h11, 32'hFFFFFF55, st, bok, to);
    issue(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 3'b010, 5'd9, 32'd0, 32'h10, 32'd0, st, bok, to);
    checks++;
    if (to || o_data !== 32'h11225544) begin
      failures++; $display("FAIL sb_merge: got %h want 11225544", o_data);
    end
  endtask

  task automatic test_rw_both();
    int st; bit bok, to;
    issue(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'b010, 5'd0, 32'd0, 32'h40, 32'h01020304, st, bok, to);
    issue(1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 3'b010, 5'd4, 32'd0, 32'h40, 32'hCAFEF00D, st, bok, to);
    checks++;
    if (to || o_data !== 32'h01020304) begin
      failures++; $display("FAIL rw_both_pre: got %h want 01020304", o_data);
    end
    issue(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 3'b010, 5'd4, 32'd0, 32'h40, 32'd0, st, bok, to);
    checks++;
    if (to || o_data !== 32'hCAFEF00D) begin
      failures++; $display("FAIL rw_both_post: got %h want CAFEF00D", o_data);
    end
  endtask

  task automatic test_wrap();
    int st; bit bok, to;
    issue(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'b010, 5'd0, 32'd0, 32'h400, 32'h00001234, st, bok, to);
    issue(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 3'b010, 5'd2, 32'd0, 32'h000, 32'd0, st, bok, to);
    checks++;
    if (to || o_data !== 32'h00001234) begin
      failures++; $display("FAIL wrap: got %h want 00001234", o_data);
    end
  endtask

  task automatic test_latency();
    int st; bit bok, to;
    issue(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 3'b010, 5'd0, 32'd0, 32'h20, 32'h5A5A5A5A, st, bok, to);
    checks++;
    if (to || st != Lat || !bok) begin
      failures++; $display("FAIL sw_latency: got stalls=%0d bubbles_ok=%b want %0d 1", st, bok, Lat);
    end
    issue(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 3'b010, 5'd11, 32'h200, 32'h20, 32'd0, st, bok, to);
    checks++;
    if (to || st != Lat || !bok || o_rw !== 1'b1 || o_rd !== 5'd11 || o_data !== 32'h5A5A5A5A)
    begin
      failures++; $display("FAIL lw_latency: got stalls=%0d bok=%b rw=%b data=%h want %0d 1 1 5A5A5A5A",
                           st, bok, o_rw, o_data, Lat);
    end
  endtask

  task automatic test_back_to_back();
    int st1, st2; bit bok1, bok2, to1, to2;
    issue(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 3'b100, 5'd1, 32'd0, 32'h21, 32'd0, st1, bok1, to1);
    issue(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 3'b001, 5'd2, 32'd0, 32'h22, 32'd0, st2, bok2, to2);
    checks++;
    if (to1 || to2 || st1 != Lat || st2 != Lat || !bok1 || !bok2 || o_data !== 32'h00005A5A) begin
      failures++; $display("FAIL back_to_back: got stalls=%0d,%0d data=%h want %0d,%0d 00005A5A",
                           st1, st2, o_data, Lat, Lat);
    end
  endtask

  task automatic test_misaligned();
    int st; bit bok, to;
    logic exp_mis;
    logic [31:0] exp_word;
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
    exp_mis = 1'b1; exp_word = 32'h5A5A5A5A;
`else
    exp_mis = 1'b0; exp_word = 32'hAAAAAAAA;
`endif
    issue(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 3'b010, 5'd6, 32'd0, 32'h22, 32'hAAAAAAAA, st, bok, to);
    checks++;
    if (to || o_mis !== exp_mis || o_rw !== !exp_mis || st != (exp_mis ? 0 : Lat)) begin
      failures++; $display("FAIL misaligned_sw: got mis=%b rw=%b stalls=%0d want mis=%b", o_mis,
                           o_rw, st, exp_mis);
    end
    issue(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 3'b010, 5'd6, 32'd0, 32'h20, 32'd0, st, bok, to);
    checks++;
    if (to || o_data !== exp_word || o_mis !== 1'b0) begin
      failures++; $display("FAIL misaligned_word: got %h want %h", o_data, exp_word);
    end
  endtask

  task automatic test_reset_mid_busy();
    int st; bit bok, to;
    issue(1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 3'b010, 5'd5, 32'h4, 32'h30, 32'h0BADF00D, st, bok, to);
    sel = 1'b1; m_mw = 1'b1; m_f3 = 3'b010; m_alu = 32'h30; m_wd = 32'hFFFFFFFF; m_rw = 1'b1;
    @(negedge clk);
    checks++;
    if (o_stall !== 1'b1) begin
      failures++; $display("FAIL busy_entry_stall: got %b want 1", o_stall);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if (o_stall !== 1'b0 || {o_rw, o_mis, o_rs, o_rd, o_pc, o_alu, o_data} !== '0) begin
      failures++; $display("FAIL reset_mid_busy: got stall=%b rw=%b rd=%h want 0 0 0", o_stall,
                           o_rw, o_rd);
    end
    m_mw = 1'b0; m_rw = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    issue(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 3'b010, 5'd5, 32'd0, 32'h30, 32'd0, st, bok, to);
    checks++;
    if (to || o_data !== 32'h0BADF00D) begin
      failures++; $display("FAIL reset_no_write: got %h want 0BADF00D", o_data);
    end
  endtask

  task automatic test_random(input bit slow, input int n);
    int st; bit bok, to;
    int unsigned k, wi;
    logic rw, mw, mr, mis;
    logic [1:0] rs;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [31:0] addr, wd, pc, exp_data;
    logic [2:0] ld_tab [5];
    ld_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int w = 0; w < 16; w++) begin
      wd = $urandom();
      addr = 32'h100 + 32'(4 * w);
      issue(slow, 1'b0, 1'b1, 1'b0, 2'd0, 3'b010, 5'd0, 32'd0, addr, wd, st, bok, to);
      mdl[slow][(addr >> 2) % Depth] = wd;
    end
    for (int i = 0; i < n; i++) begin
      k  = $urandom_range(0, 3);
      mr = (k == 1 || k == 3);
      mw = (k >= 2);
      f3 = mw ? 3'($urandom_range(0, 2)) : ld_tab[$urandom_range(0, 4)];
      rw = 1'($urandom_range(0, 1));
      rs = 2'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 31));
      pc = $urandom();
      wd = $urandom();
      addr = ($urandom() & 32'hFFFF_FC00) | (32'h100 + 32'($urandom_range(0, 63)));
      wi = (addr >> 2) % Depth;
      mis = (mr || mw) && mdl_mis(f3, addr[1:0]);
      exp_data = mdl_load(mdl[slow][wi], f3, addr[1:0]);
      if (mw && !mis) mdl[slow][wi] = mdl_store(mdl[slow][wi], wd, f3, addr[1:0]);
      issue(slow, rw, mw, mr, rs, f3, rd, pc, addr, wd, st, bok, to);
      checks++;
      if (to || !bok || st != ((slow && (mr || mw) && !mis) ? Lat : 0)) begin
        failures++; $display("FAIL rand_timing[%0d]: got stalls=%0d bok=%b to=%b", i, st, bok, to);
      end
      checks++;
      if ({o_rw, o_mis, o_rs, o_rd, o_pc, o_alu} !== {rw & ~mis, mis, rs, rd, pc, addr}) begin
        failures++; $display("FAIL rand_fields[%0d]: got rw=%b mis=%b rd=%h alu=%h want %b %b %h %h",
                             i, o_rw, o_mis, o_rd, o_alu, rw & ~mis, mis, rd, addr);
      end
      if (!mis) begin
        checks++;
        if (o_data !== exp_data) begin
          failures++; $display("FAIL rand_data[%0d]: got %h want %h (f3=%b addr=%h)", i, o_data,
                               exp_data, f3, addr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fast_loads();
    test_sb_merge();
    test_rw_both();
    test_wrap();
    test_latency();
    test_back_to_back();
    test_misaligned();
    test_reset_mid_busy();
    test_random(1'b0, 200);
    test_random(1'b1, 40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
